xillybus_sad_engine: RTL and testbench

//  User-side endpoint for the Xillybus core's FIFO streams. Consumes host words on write_32_a (probe) and write_32_b (candidate); each word holds 4 packed pixels.

---
 rtl/xillybus_sad_engine.sv | 164 ++++++++++++++++
 tb/tb_xillybus_sad_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/xillybus_sad_engine.sv
// Xillybus user-side SAD engine: pairs probe/candidate pixel words from two
// host FIFOs and returns one saturating 32-bit SAD score per VEC_LEN-word vector.
module xillybus_sad_engine #(
  parameter int unsigned VEC_LEN = 1024,
  parameter int unsigned IN_AW   = 4,
  parameter int unsigned RES_AW  = 4
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  input  logic        user_w_write_32_a_wren,
  input  logic [31:0] user_w_write_32_a_data,
  output logic        user_w_write_32_a_full,
  input  logic        user_w_write_32_a_open,
  input  logic        user_w_write_32_b_wren,
  input  logic [31:0] user_w_write_32_b_data,
  output logic        user_w_write_32_b_full,
  input  logic        user_w_write_32_b_open,
  input  logic        user_r_read_32_result_rden,
  output logic [31:0] user_r_read_32_result_data,
  output logic        user_r_read_32_result_empty,
  output logic        user_r_read_32_result_eof,
  input  logic        user_r_read_32_result_open,
  output logic        err_overflow
);

  localparam int unsigned IN_DEPTH  = 1 << IN_AW;
  localparam int unsigned RES_DEPTH = 1 << RES_AW;
  localparam int unsigned CW        = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic               prev_open_a, prev_open_b;
  logic [31:0]        a_mem [IN_DEPTH];
  logic [31:0]        b_mem [IN_DEPTH];
  logic [IN_AW-1:0]   a_wp, a_rp, b_wp, b_rp;
  logic [IN_AW:0]     a_cnt, b_cnt;
  logic [31:0]        res_mem [RES_DEPTH];
  logic [RES_AW-1:0]  res_wp, res_rp;
  logic [RES_AW:0]    res_cnt;
  logic               v1, v2;
  logic [7:0]         d [4];
  logic [9:0]         s2_sum;
  logic [31:0]        acc;
  logic [CW-1:0]      wcnt;

  logic        a_full, b_full, a_push, b_push, pop, rise, drain_done;
  logic        res_empty, res_pop, res_push, last;
  logic [31:0] a_head, b_head, acc_next;
  logic [32:0] sum33;

  function automatic logic [7:0] absd(input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? x - y : y - x;
  endfunction

  always_comb begin
    a_full     = (a_cnt == (IN_AW+1)'(IN_DEPTH));
    b_full     = (b_cnt == (IN_AW+1)'(IN_DEPTH));
    res_empty  = (res_cnt == '0);
    // closed streams only accept data while idle or running
    a_push     = user_w_write_32_a_wren && !a_full &&
                 (user_w_write_32_a_open || state == IDLE || state == RUN);
    b_push     = user_w_write_32_b_wren && !b_full &&
                 (user_w_write_32_b_open || state == IDLE || state == RUN);
    // two result slots stay reserved for words already in the pipeline
    pop        = (state == RUN || state == DRAIN) && (a_cnt != '0) && (b_cnt != '0) &&
                 (res_cnt <= (RES_AW+1)'(RES_DEPTH - 3));
    rise       = (user_w_write_32_a_open && !prev_open_a) ||
                 (user_w_write_32_b_open && !prev_open_b);
    drain_done = (state == DRAIN) && !((a_cnt != '0) && (b_cnt != '0)) && !v1 && !v2;
    res_pop    = user_r_read_32_result_rden && !res_empty;
    last       = (wcnt == CW'(VEC_LEN - 1));
    res_push   = v2 && last;
    a_head     = a_mem[a_rp];
    b_head     = b_mem[b_rp];
    sum33      = {1'b0, acc} + 33'(s2_sum);
    acc_next   = sum33[32] ? '1 : sum33[31:0];
  end

  assign user_w_write_32_a_full      = a_full;
  assign user_w_write_32_b_full      = b_full;
  assign user_r_read_32_result_empty = res_empty;
  assign user_r_read_32_result_eof   = (state == DONE) && res_empty;

  always_ff @(posedge bus_clk) begin
    if (a_push) a_mem[a_wp] <= user_w_write_32_a_data;
    if (b_push) b_mem[b_wp] <= user_w_write_32_b_data;
    if (res_push) res_mem[res_wp] <= acc_next;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state                      <= IDLE;
      prev_open_a                <= 1'b0;
      prev_open_b                <= 1'b0;
      a_wp <= '0; a_rp <= '0; a_cnt <= '0;
      b_wp <= '0; b_rp <= '0; b_cnt <= '0;
      res_wp <= '0; res_rp <= '0; res_cnt <= '0;
      v1 <= 1'b0; v2 <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) d[i] <= '0;
      s2_sum                     <= '0;
      acc                        <= '0;
      wcnt                       <= '0;
      user_r_read_32_result_data <= '0;
      err_overflow               <= 1'b0;
    end else begin
      prev_open_a <= user_w_write_32_a_open;
      prev_open_b <= user_w_write_32_b_open;

      if (state == IDLE && rise)
        err_overflow <= 1'b0;
      else if ((user_w_write_32_a_wren && a_full) || (user_w_write_32_b_wren && b_full))
        err_overflow <= 1'b1;

      if (drain_done) begin
        a_wp <= '0; a_rp <= '0; a_cnt <= '0;
        b_wp <= '0; b_rp <= '0; b_cnt <= '0;
      end else begin
        if (a_push) a_wp <= a_wp + 1'b1;
        if (b_push) b_wp <= b_wp + 1'b1;
        if (pop) begin
          a_rp <= a_rp + 1'b1;
          b_rp <= b_rp + 1'b1;
        end
        a_cnt <= a_cnt + (IN_AW+1)'(a_push) - (IN_AW+1)'(pop);
        b_cnt <= b_cnt + (IN_AW+1)'(b_push) - (IN_AW+1)'(pop);
      end

      v1 <= pop;
      if (pop)
        for (int unsigned i = 0; i < 4; i++)
          d[i] <= absd(a_head[8*i +: 8], b_head[8*i +: 8]);
      v2     <= v1;
      s2_sum <= 10'(d[0]) + 10'(d[1]) + 10'(d[2]) + 10'(d[3]);

      if (drain_done || res_push) begin
        acc  <= '0;
        wcnt <= '0;
      end else if (v2) begin
        acc  <= acc_next;
        wcnt <= wcnt + 1'b1;
      end

      if (res_push) res_wp <= res_wp + 1'b1;
      if (res_pop) begin
        res_rp                     <= res_rp + 1'b1;
        user_r_read_32_result_data <= res_mem[res_rp];
      end
      res_cnt <= res_cnt + (RES_AW+1)'(res_push) - (RES_AW+1)'(res_pop);

      unique case (state)
        IDLE:  if (rise) state <= RUN;
        RUN:   if (!user_w_write_32_a_open && !user_w_write_32_b_open) state <= DRAIN;
        DRAIN: if (drain_done) state <= DONE;
        DONE: begin
          if (rise) state <= RUN;
          else if (!user_r_read_32_result_open && res_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xillybus_sad_engine.sv
// Directed bench for xillybus_sad_engine: one VEC_LEN=4 instance and one
// VEC_LEN=1 / RES_AW=2 instance, checked with immediate assertions.
module tb_xillybus_sad_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // instance with VEC_LEN=4
  logic        rst4, wa4, wb4, fa4, fb4, oa4, ob4, rd4, em4, eof4, or4, err4;
  logic [31:0] da4, db4, q4;
  // instance with VEC_LEN=1, RES_AW=2
  logic        rst1, wa1, wb1, fa1, fb1, oa1, ob1, rd1, em1, eof1, or1, err1;
  logic [31:0] da1, db1, q1;

  xillybus_sad_engine #(.VEC_LEN(4), .IN_AW(4), .RES_AW(4)) u4 (
    .bus_clk(clk), .bus_rst(rst4),
    .user_w_write_32_a_wren(wa4), .user_w_write_32_a_data(da4),
    .user_w_write_32_a_full(fa4), .user_w_write_32_a_open(oa4),
    .user_w_write_32_b_wren(wb4), .user_w_write_32_b_data(db4),
    .user_w_write_32_b_full(fb4), .user_w_write_32_b_open(ob4),
    .user_r_read_32_result_rden(rd4), .user_r_read_32_result_data(q4),
    .user_r_read_32_result_empty(em4), .user_r_read_32_result_eof(eof4),
    .user_r_read_32_result_open(or4), .err_overflow(err4)
  );

  xillybus_sad_engine #(.VEC_LEN(1), .IN_AW(4), .RES_AW(2)) u1 (
    .bus_clk(clk), .bus_rst(rst1),
    .user_w_write_32_a_wren(wa1), .user_w_write_32_a_data(da1),
    .user_w_write_32_a_full(fa1), .user_w_write_32_a_open(oa1),
    .user_w_write_32_b_wren(wb1), .user_w_write_32_b_data(db1),
    .user_w_write_32_b_full(fb1), .user_w_write_32_b_open(ob1),
    .user_r_read_32_result_rden(rd1), .user_r_read_32_result_data(q1),
    .user_r_read_32_result_empty(em1), .user_r_read_32_result_eof(eof1),
    .user_r_read_32_result_open(or1), .err_overflow(err1)
  );

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pair4(input logic [31:0] a, input logic [31:0] b);
    wa4 = 1'b1; da4 = a; wb4 = 1'b1; db4 = b;
    tick();
    wa4 = 1'b0; wb4 = 1'b0;
  endtask

  task automatic pair1(input logic [31:0] a, input logic [31:0] b);
    wa1 = 1'b1; da1 = a; wb1 = 1'b1; db1 = b;
    tick();
    wa1 = 1'b0; wb1 = 1'b0;
  endtask

  task automatic read4();
    rd4 = 1'b1;
    tick();
    rd4 = 1'b0;
  endtask

  task automatic read1();
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
  endtask

  initial begin
    rst4 = 1'b1; wa4 = 1'b0; wb4 = 1'b0; oa4 = 1'b0; ob4 = 1'b0; rd4 = 1'b0; or4 = 1'b0;
    da4 = '0; db4 = '0;
    rst1 = 1'b1; wa1 = 1'b0; wb1 = 1'b0; oa1 = 1'b0; ob1 = 1'b0; rd1 = 1'b0; or1 = 1'b0;
    da1 = '0; db1 = '0;
    @(negedge clk);
    tick(2);

    chk("rst_full_a", 32'(fa4), 32'd0);
    chk("rst_full_b", 32'(fb4), 32'd0);
    chk("rst_empty", 32'(em4), 32'd1);
    chk("rst_eof", 32'(eof4), 32'd0);
    chk("rst_data", q4, 32'h0);
    chk("rst_err", 32'(err4), 32'd0);
    rst4 = 1'b0;
    rst1 = 1'b0;

    // one full vector: 29 per word, 4 words
    or4 = 1'b1; oa4 = 1'b1; ob4 = 1'b1;
    tick();
    repeat (4) pair4(32'h10203040, 32'h0F223A50);
    tick(2);
    chk("lat_empty_t2", 32'(em4), 32'd1);
    tick();
    chk("lat_empty_t3", 32'(em4), 32'd0);
    read4();
    chk("vec4_score", q4, 32'h00000074);
    chk("vec4_empty_after", 32'(em4), 32'd1);

    // 6 pairs then close: one result, the partial vector is discarded
    repeat (6) pair4(32'h10203040, 32'h0F223A50);
    tick(6);
    oa4 = 1'b0; ob4 = 1'b0;
    tick(5);
    chk("drain_one_result", 32'(em4), 32'd0);
    chk("drain_eof_pending", 32'(eof4), 32'd0);
    read4();
    chk("drain_score", q4, 32'h00000074);
    chk("drain_empty", 32'(em4), 32'd1);
    chk("drain_eof", 32'(eof4), 32'd1);
    read4();
    chk("rden_empty_hold", q4, 32'h00000074);
    oa4 = 1'b1;
    tick();
    chk("reopen_eof", 32'(eof4), 32'd0);

    // overflow on A with B empty
    for (int unsigned i = 0; i < 16; i++) begin
      wa4 = 1'b1; da4 = 32'(i);
      tick();
    end
    wa4 = 1'b0;
    chk("fill_full", 32'(fa4), 32'd1);
    chk("fill_err_clear", 32'(err4), 32'd0);
    wa4 = 1'b1; da4 = 32'hDEAD0000;
    tick();
    wa4 = 1'b0;
    chk("ovf_full", 32'(fa4), 32'd1);
    chk("ovf_err", 32'(err4), 32'd1);
    oa4 = 1'b0; or4 = 1'b0;
    tick(4);
    chk("flush_full", 32'(fa4), 32'd0);
    chk("err_sticky", 32'(err4), 32'd1);
    oa4 = 1'b1;
    tick();
    chk("reopen_err", 32'(err4), 32'd0);

    // reset in the middle of a vector
    or4 = 1'b1;
    for (int unsigned i = 0; i < 17; i++) begin
      wa4 = 1'b1; da4 = 32'h01010101;
      tick();
    end
    wa4 = 1'b0;
    chk("pre_rst_err", 32'(err4), 32'd1);
    ob4 = 1'b1;
    wb4 = 1'b1; db4 = 32'h0;
    tick(2);
    rst4 = 1'b1;
    tick();
    wb4 = 1'b0;
    rst4 = 1'b0;
    chk("mid_rst_empty", 32'(em4), 32'd1);
    chk("mid_rst_full_a", 32'(fa4), 32'd0);
    chk("mid_rst_full_b", 32'(fb4), 32'd0);
    chk("mid_rst_eof", 32'(eof4), 32'd0);
    chk("mid_rst_err", 32'(err4), 32'd0);
    tick();
    repeat (4) pair4(32'hFF00FF00, 32'h00FF00FF);
    tick(6);
    read4();
    chk("post_rst_score", q4, 32'h00000FF0);

    // VEC_LEN=1 scores
    or1 = 1'b1; oa1 = 1'b1; ob1 = 1'b1;
    tick();
    pair1(32'hFF00FF00, 32'h00FF00FF);
    pair1(32'h12345678, 32'h12345678);
    tick(5);
    read1();
    chk("v1_max_diff", q1, 32'h000003FC);
    read1();
    chk("v1_equal", q1, 32'h00000000);
    chk("v1_empty", 32'(em1), 32'd1);

    // result FIFO of 4 fills, pairs back up into full input FIFOs
    for (int unsigned k = 1; k <= 20; k++) pair1(32'(k), 32'h0);
    tick(5);
    chk("stall_full_a", 32'(fa1), 32'd1);
    chk("stall_full_b", 32'(fb1), 32'd1);
    chk("stall_err", 32'(err1), 32'd0);
    chk("stall_nonempty", 32'(em1), 32'd0);
    for (int unsigned k = 1; k <= 20; k++) begin
      read1();
      chk($sformatf("stall_order_%0d", k), q1, 32'(k));
      tick(5);
    end
    chk("stall_drained", 32'(em1), 32'd1);
    chk("stall_full_clear", 32'(fa1), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
